// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor. Computes diff = a - b mod
//            2^WIDTH, one bit per clock, LSB first, using full-subtractor
//            logic and a single borrow flop. A three-state FSM
//            (IDLE -> RUN -> DONE -> IDLE) sequences each operation.
//
// Ports    : clk    in   1      clock, all state changes on rising edge
//            rst    in   1      synchronous active-high reset
//            start  in   1      begin an operation (sampled only in IDLE)
//            a      in   WIDTH  minuend, captured on accepted start
//            b      in   WIDTH  subtrahend, captured on accepted start
//            busy   out  1      high in RUN and DONE
//            done   out  1      one-cycle pulse, diff/borrow valid
//            diff   out  WIDTH  a - b mod 2^WIDTH
//            borrow out  1      final borrow, 1 iff a < b (unsigned)
//
// Timing   : start sampled at edge k -> done high in the cycle after edge
//            k+WIDTH. Back-to-back operations repeat every WIDTH+2 cycles.
//
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(WIDTH);

    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;        // minuend shift register, bit 0 is current
    logic [WIDTH-1:0]   r_b;        // subtrahend shift register
    // Only WIDTH-1 result bits are ever held here: the final bit is produced
    // combinationally on the completing edge and concatenated on top.
    logic [WIDTH-2:0]   r_res;
    logic               r_br;       // running borrow between bit positions
    logic [c_cnt_w-1:0] r_cnt;      // index of the bit processed this cycle
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    // ------------------------------------------------------------------------
    // Full-subtractor slice on the current LSBs
    // ------------------------------------------------------------------------
    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-2:0] w_res_shift;
    logic [WIDTH-1:0] w_res_full;
    logic             w_last;

    assign w_a0      = r_a[0];
    assign w_b0      = r_b[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_br;
    assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_last    = (r_cnt == c_last_bit);

    // New difference bit enters at the MSB; the register shifts right.
    generate
        if (WIDTH > 2) begin : g_res_wide
            assign w_res_shift = {w_d, r_res[WIDTH-2:1]};
        end else begin : g_res_narrow
            assign w_res_shift = w_d;
        end
    endgenerate

    // On the last bit, r_res already holds bits [WIDTH-2:0] in place.
    assign w_res_full = {w_d, r_res};

    // ------------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                    end
                end

                c_st_run: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_shift;
                    r_cnt <= r_cnt + 1'b1;
                    // Outputs are updated only here so they never expose a
                    // partially computed result.
                    if (w_last) begin
                        r_diff   <= w_res_full;
                        r_borrow <= w_br_next;
                        r_state  <= c_st_done;
                    end
                end

                c_st_done: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy   = (r_state == c_st_run) || (r_state == c_st_done);
    assign done   = (r_state == c_st_done);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8). The
//            driver pushes expected results into a queue at acceptance; an
//            independent monitor pops and compares on every done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W   = 8;
    localparam int PER = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    typedef struct {
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] ed;
        logic         ebr;
        time          t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    time  last_acc = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input time t);
        exp_t e;
        int   xi;
        int   yi;
        xi      = int'(x);
        yi      = int'(y);
        e.ea    = x;
        e.eb    = y;
        e.ed    = W'((xi - yi) & ((1 << W) - 1));
        e.ebr   = (xi < yi);
        e.t_acc = t;
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------------
    logic         rst_s     = 1'b1;
    logic         prev_done = 1'b0;
    logic [W-1:0] prev_diff = '0;
    logic         prev_br   = 1'b0;

    always @(posedge clk) rst_s = rst;

    always @(negedge clk) begin
        if (done) begin
            check("done_busy", busy, 1);
            check("done_single_pulse", prev_done, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", diff, e.ed);
                check("borrow", borrow, e.ebr);
                check("latency", longint'($time), longint'(e.t_acc + W*PER + PER/2));
            end
        end else if (!rst_s) begin
            // Outputs may only move on the completing edge or on reset.
            check("diff_stable", diff, prev_diff);
            check("borrow_stable", borrow, prev_br);
        end
        prev_done = done;
        prev_diff = diff;
        prev_br   = borrow;
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 4*W) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Called #1 after a rising edge; the start is accepted at the next edge.
    task automatic issue_op(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        last_acc = $time;
        exp_q.push_back(model(x, y, $time));
        #1;
        start = 1'b0;
        // Operands changing after acceptance must have no effect.
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        time t1;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        idle_cycles(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        rst = 1'b0;

        // Cases 1-3
        issue_op(8'h05, 8'h03);
        issue_op(8'h03, 8'h05);
        issue_op(8'h00, 8'h00);

        // Case 4: back-to-back, second start in the first IDLE cycle
        issue_op(8'hFF, 8'h01);
        t1 = last_acc;
        issue_op(8'h80, 8'hFF);
        check("b2b_spacing", longint'(last_acc - t1), longint'((W + 2) * PER));

        // Case 5: start during RUN cycle 3 must be ignored
        issue_op(8'h10, 8'h01);
        idle_cycles(2);
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
        idle_cycles(1);
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        wait_idle();
        idle_cycles(2);
        check("ignored_start_busy", busy, 0);

        // Case 6: reset during RUN cycle 4 aborts without a done pulse
        issue_op(8'h33, 8'h11);
        idle_cycles(3);
        rst = 1'b1;
        exp_q.delete();
        idle_cycles(1);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        idle_cycles(W + 3);
        issue_op(8'h09, 8'h04);

        // Randomised operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = (i % 8 == 0) ? x : W'($urandom);
            issue_op(x, y);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        wait_idle();
        idle_cycles(2);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #(PER * 20000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend (unsigned), captured on accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend (unsigned), captured on accepted start.
REQ-007 Port: busy  output  1  high while an operation is in progress (RUN or DONE state).
REQ-008 Port: done  output  1  single-cycle pulse: result valid.
REQ-009 Port: diff  output  WIDTH  result a - b mod 2^WIDTH.
REQ-010 Port: borrow  output  1  final borrow out; 1 iff a < b (unsigned).

Function
REQ-011 The block SHALL compute a - b bit-serially, LSB first, processing one bit per clock using half/full-subtractor logic.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE -> RUN on a rising edge with start=1: load a and b into internal shift registers, clear the internal borrow flop, clear the bit counter to 0.
REQ-014 In IDLE with start=0, the block SHALL hold state; diff and borrow keep their last values.
REQ-015 In RUN, on each edge: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br); d shifts into the MSB of the internal result register (right shift); the a and b shift registers shift right by one; the counter increments.
REQ-016 RUN -> DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1); on that same edge, diff SHALL be loaded with the completed result and borrow with br_next.
REQ-017 DONE SHALL last exactly one cycle, with done=1; DONE -> IDLE unconditionally.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high during the cycle that follows edge k+WIDTH, i.e. WIDTH+1 clocks after acceptance.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 The block SHALL ignore start while busy=1 (RUN or DONE); no queuing; operands in flight are not disturbed.
REQ-021 The block SHALL ignore changes on a and b after acceptance; only the captured values are used.
REQ-022 diff and borrow SHALL change only at the REQ-016 edge or on reset, never during RUN.
REQ-023 A start in the first IDLE cycle after DONE SHALL be accepted normally; back-to-back operations therefore occur every WIDTH+2 cycles.
REQ-024 Borrow semantics SHALL be unsigned: a=b gives diff=0 and borrow=0; a<b gives the two's-complement wrap and borrow=1.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE; busy=0; done=0; diff=0; borrow=0; internal shift registers, borrow flop, and counter are cleared.
REQ-026 rst SHALL take priority over start and over every FSM transition.
REQ-027 A reset during RUN or DONE SHALL abort the operation; no done pulse occurs for it.
REQ-028 The first start after reset release SHALL be accepted on the first edge with rst=0 and start=1.

Verification (WIDTH=8)
REQ-029 Case 1: a=0x05, b=0x03, start pulse -> diff=0x02, borrow=0; done is high exactly 9 clocks after the accepting edge.
REQ-030 Case 2: a=0x03, b=0x05 -> diff=0xFE, borrow=1. Case 3: a=0x00, b=0x00 -> diff=0x00, borrow=0.
REQ-031 Case 4: a=0xFF, b=0x01, then a=0x80, b=0xFF back-to-back -> diff=0xFE, borrow=0; then diff=0x81, borrow=1; the second start is accepted in the first IDLE cycle.
REQ-032 Case 5: start on 0x10-0x01; at RUN cycle 3, assert start with a=0x00, b=0xFF and change a and b -> the second start is ignored; result is diff=0x0F, borrow=0; only one done pulse occurs.
REQ-033 Case 6: rst=1 during RUN cycle 4 -> the next cycle shows busy=0, done=0, diff=0x00, borrow=0; no done pulse appears; a subsequent 0x09-0x04 gives diff=0x05.
REQ-034 The bench SHALL compare every case against a reference model (a-b)&0xFF and borrow=(a<b), and check that done is a single-cycle pulse.
